watch_dp: RTL

// - Timekeeping datapath for the watch: runs hour/min/sec/centisecond counters from the system clock.
// - Sits directly downstream of the watch control unit; consumes its registered digit_mode/inc/dec/clear.
// - Outputs binary time fields to the FND display formatter.

---
 rtl/watch_pkg.sv | 28 ++
 rtl/watch_dp_if.sv | 22 ++
 rtl/watch_dp_tick_gen.sv | 33 +++
 rtl/watch_dp.sv | 85 ++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared definitions for the watch: mode encodings, field limits/widths and a wrap helper.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_ADJ_SEC  = 2'b01,
    MODE_ADJ_MIN  = 2'b10,
    MODE_ADJ_HOUR = 2'b11
  } mode_e;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam int MSEC_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // One step up or down inside 0..max_v, wrapping at both ends.
  function automatic logic [6:0] step_wrap(input logic [6:0] v, input logic [6:0] max_v,
                                           input logic up);
    if (up) return (v == max_v) ? 7'd0 : v + 7'd1;
    return (v == 7'd0) ? max_v : v - 7'd1;
  endfunction

endpackage

// File: rtl/watch_dp_if.sv
// Control-unit to datapath bundle: mode and one-cycle command pulses in, registered time fields out.
// Handshake: no valid/ready; inc/dec/clear are single-cycle pulses acted on at the edge that samples
// them, and the time fields/tick are always valid, updated one edge after the causing input.
interface watch_dp_if;
  import watch_pkg::*;

  logic [1:0]        digit_mode;
  logic              inc;
  logic              dec;
  logic              clear;
  logic [MSEC_W-1:0] msec;
  logic [SEC_W-1:0]  sec;
  logic [MIN_W-1:0]  min;
  logic [HOUR_W-1:0] hour;
  logic              tick;

  modport master (output digit_mode, inc, dec, clear,
                  input  msec, sec, min, hour, tick);
  modport slave  (input  digit_mode, inc, dec, clear,
                  output msec, sec, min, hour, tick);

endinterface

// File: rtl/watch_dp_tick_gen.sv
// Centisecond prescaler: counts while enabled, holds when disabled, flags the wrapping cycle.
module tick_gen #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned TICK_HZ  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // clr wins over the wrap so a clear never produces a tick in the same cycle.
  assign tick = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/watch_dp.sv
// Watch timekeeping datapath: hh:mm:ss.cc counters with RUN ripple-carry and per-field adjust.
module watch_dp
  import watch_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       rst,
  watch_dp_if.slave  bus
);

  logic run, pre_tick;
  logic [MSEC_W-1:0] msec_q, msec_d;
  logic [SEC_W-1:0]  sec_q,  sec_d;
  logic [MIN_W-1:0]  min_q,  min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              tick_q, tick_d;

  assign run = (bus.digit_mode == MODE_RUN);

  tick_gen #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (bus.clear),
    .tick (pre_tick)
  );

  always_comb begin
    msec_d = msec_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    tick_d = 1'b0;
    if (bus.clear) begin
      msec_d = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (!run && (bus.inc || bus.dec)) begin
      // inc outranks dec; adjusting never carries into neighbouring fields.
      case (mode_e'(bus.digit_mode))
        MODE_ADJ_SEC:  sec_d  = SEC_W'(step_wrap(7'(sec_q), 7'(SEC_MAX), bus.inc));
        MODE_ADJ_MIN:  min_d  = MIN_W'(step_wrap(7'(min_q), 7'(MIN_MAX), bus.inc));
        MODE_ADJ_HOUR: hour_d = HOUR_W'(step_wrap(7'(hour_q), 7'(HOUR_MAX), bus.inc));
        default: ;
      endcase
    end else if (pre_tick) begin
      tick_d = 1'b1;
      msec_d = MSEC_W'(step_wrap(msec_q, 7'(MSEC_MAX), 1'b1));
      if (msec_q == MSEC_W'(MSEC_MAX)) begin
        sec_d = SEC_W'(step_wrap(7'(sec_q), 7'(SEC_MAX), 1'b1));
        if (sec_q == SEC_W'(SEC_MAX)) begin
          min_d = MIN_W'(step_wrap(7'(min_q), 7'(MIN_MAX), 1'b1));
          if (min_q == MIN_W'(MIN_MAX))
            hour_d = HOUR_W'(step_wrap(7'(hour_q), 7'(HOUR_MAX), 1'b1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      tick_q <= 1'b0;
    end else begin
      msec_q <= msec_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      tick_q <= tick_d;
    end
  end

  assign bus.msec = msec_q;
  assign bus.sec  = sec_q;
  assign bus.min  = min_q;
  assign bus.hour = hour_q;
  assign bus.tick = tick_q;

endmodule
